// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the CALC phase.
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  kill,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [1:0] OP_DIV = 2'b00;
  localparam logic [1:0] OP_REM = 2'b10;

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic           a_neg_q, a_neg_d;
  logic           b_neg_q, b_neg_d;
  logic           div0_q, div0_d;
  logic           ovf_q, ovf_d;
  logic [W-1:0]   a_raw_q, a_raw_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   result_q, result_d;
  logic           valid_q, valid_d;

  logic           signed_op;
  logic [W-1:0]   a_mag, b_mag;
  logic           div0_in, ovf_in;
  logic [W:0]     rem_shift, rem_diff;
  logic           ge;
  logic [W-1:0]   q_fix, r_fix, final_res;

  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && a[W-1]) ? -a : a;
    b_mag     = (signed_op && b[W-1]) ? -b : b;
    div0_in   = (b == '0);
    ovf_in    = signed_op && (a == MIN_NEG) && (b == '1);

    // The extra top bit keeps divisors >= 2^(W-1) from losing the partial remainder MSB.
    rem_shift = {rem_q, quo_q[W-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    ge        = (rem_shift >= {1'b0, dvs_q});

    q_fix = ((op_q == OP_DIV) && (a_neg_q ^ b_neg_q)) ? -quo_q : quo_q;
    r_fix = ((op_q == OP_REM) && a_neg_q) ? -rem_q : rem_q;
    if (!op_q[1]) begin
      final_res = div0_q ? '1 : (ovf_q ? MIN_NEG : q_fix);
    end else begin
      final_res = div0_q ? a_raw_q : (ovf_q ? '0 : r_fix);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    a_raw_d  = a_raw_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          op_d    = op;
          a_neg_d = signed_op & a[W-1];
          b_neg_d = signed_op & b[W-1];
          div0_d  = div0_in;
          ovf_d   = ovf_in;
          a_raw_d = a;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          cnt_d   = '0;
`ifdef DIV_EARLY_OUT_EN
          state_d = (div0_in || ovf_in) ? S_DONE : S_CALC;
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC: begin
        quo_d = {quo_q[W-2:0], ge};
        rem_d = ge ? rem_diff[W-1:0] : rem_shift[W-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        result_d = final_res;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything, including a completing DONE.
    if (kill) begin
      state_d  = S_IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_raw_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      a_raw_q  <= a_raw_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // valid is registered one edge after DONE, so busy covers that cycle as well.
  assign busy   = (state_q != S_IDLE) || valid_q;
  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes model results, a negedge monitor pops on valid.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] last_res = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    case (o)
      2'b00: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sx / sy);
      end
      2'b01: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      2'b10: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sx % sy);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bit special;
    special = (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
    return special ? 1 : 33;
`else
    return special ? 33 : 33;
`endif
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=%h expected=no_valid", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Call right after a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit expect_it);
    exp_t e;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (expect_it) begin
      e.res = model(o, x, y);
      e.cyc = cyc + 1 + latency(o, x, y);
      sb.push_back(e);
      last_res = e.res;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_valid expected=valid_within_40", name);
    end else begin
      chk({name, "_busy_on_valid"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({name, "_busy_after"}, 32'(busy), 32'd0);
      chk({name, "_valid_one_cycle"}, 32'(valid), 32'd0);
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    issue(o, x, y, 1'b1);
    wait_valid("op");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    kill  = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(2'b01, 32'd100, 32'd7);
    run(2'b11, 32'd100, 32'd7);
    run(2'b00, 32'hFFFF_FFF9, 32'd2);
    run(2'b10, 32'hFFFF_FFF9, 32'd2);
    run(2'b01, 32'd5, 32'd0);
    run(2'b00, 32'd5, 32'd0);
    run(2'b11, 32'd5, 32'd0);
    run(2'b10, 32'd5, 32'd0);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
    run(2'b11, 32'hFFFF_FFFF, 32'h8000_0001);

    // kill ten cycles into CALC: no valid, result holds the prior value
    issue(2'b01, 32'd12345, 32'd17, 1'b0);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_valid", 32'(valid), 32'd0);
    chk("kill_result_held", result, last_res);
    run(2'b01, 32'd9, 32'd3);

    // start mid-operation is ignored
    issue(2'b01, 32'd1000, 32'd10, 1'b1);
    repeat (4) @(negedge clk);
    op    = 2'b11;
    a     = 32'd77;
    b     = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_valid("ignored_start");
    repeat (40) @(negedge clk);

    // start together with kill in IDLE is dropped
    op    = 2'b01;
    a     = 32'd50;
    b     = 32'd5;
    start = 1'b1;
    kill  = 1'b1;
    @(posedge clk);
    #1 begin
      start = 1'b0;
      kill  = 1'b0;
    end
    @(negedge clk);
    chk("start_kill_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);

    // asynchronous reset mid-CALC
    issue(2'b00, 32'd999, 32'd4, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(valid), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    @(negedge clk);

    for (int n = 0; n < 25; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run(ro, ra, rb);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
